// File: rtl/fetch_pkg.sv
// Shared types and encodings for the instruction fetch controller.
// Holds the FSM state enum, redirect selector codes and the default PC width.
// No logic; imported by fetch_ctrl and fetch_target.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN,
    ST_HALT
  } state_t;

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JALR   = 2'b10;
  localparam logic [1:0] SEL_JAL    = 2'b11;

endpackage

// File: rtl/fetch_target.sv
// Redirect target computation: branch/JAL/JALR next-PC plus misalignment flag.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result with redirect_valid.
module fetch_target
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]      redirect_sel,
  input  logic            redirect_taken,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_off,
  input  logic [XLEN-1:0] redirect_reg,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  // Select the next PC; all adds wrap modulo 2^XLEN.
  always_comb begin
    target = redirect_base + XLEN'(4);
    case (redirect_sel)
      SEL_BRANCH: target = redirect_taken ? (redirect_base + redirect_off)
                                          : (redirect_base + XLEN'(4));
      SEL_JAL:    target = redirect_base + redirect_off;
      SEL_JALR:   target = redirect_reg & ~XLEN'(1);
      default:    target = redirect_base + XLEN'(4);
    endcase
    misalign = (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect handling, decode handoff.
// Latency: request accept to inst_valid is imem response latency + 1 cycle.
// Backpressure: instruction held stable while inst_ready is low; no new request is issued until it is taken.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_sel,
  input  logic            redirect_taken,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_off,
  input  logic [XLEN-1:0] redirect_reg,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc4,
  output logic            misalign_err
);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target;
  logic            target_misalign;
  logic            misalign_nxt;
  logic            latch_fetch;
  logic            capture;
  logic            redir;
  logic            req_fire;

  fetch_target #(.XLEN(XLEN)) u_target (
    .redirect_sel   (redirect_sel),
    .redirect_taken (redirect_taken),
    .redirect_base  (redirect_base),
    .redirect_off   (redirect_off),
    .redirect_reg   (redirect_reg),
    .target         (target),
    .misalign       (target_misalign)
  );

  // Redirects only count while the fetch engine is live.
  assign redir = redirect_valid && (redirect_sel != SEL_NONE)
                 && (state != ST_IDLE) && (state != ST_HALT);
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign imem_req_addr = pc;

  // State, PC and handoff registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      fetch_pc     <= '0;
      inst         <= '0;
      inst_pc      <= '0;
      inst_pc4     <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      misalign_err <= misalign_nxt;
      if (latch_fetch) fetch_pc <= pc;
      if (capture) begin
        inst     <= imem_rsp_data;
        inst_pc  <= fetch_pc;
        inst_pc4 <= fetch_pc + XLEN'(4);
      end
    end
  end

  // Next-state, next-PC and Moore outputs.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    misalign_nxt   = 1'b0;
    latch_fetch    = 1'b0;
    capture        = 1'b0;
    imem_req_valid = (state == ST_REQ);
    inst_valid     = (state == ST_HOLD);

    case (state)
      ST_IDLE: state_nxt = ST_REQ;

      ST_REQ: begin
        if (req_fire) latch_fetch = 1'b1;
        if (redir) begin
          // An accepted request is now stale; its response must be drained.
          pc_nxt    = target;
          state_nxt = req_fire ? ST_DRAIN : ST_REQ;
        end else if (req_fire) begin
          state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redir) begin
          // A response arriving this same cycle is the stale one: drop it here.
          pc_nxt    = target;
          state_nxt = imem_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (imem_rsp_valid) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redir) begin
          pc_nxt    = target;
          state_nxt = ST_REQ;
        end else if (inst_ready) begin
          pc_nxt    = inst_pc4;
          state_nxt = ST_REQ;
        end
      end

      ST_DRAIN: begin
        if (redir) begin
          // Leave DRAIN if the stale response lands in the same cycle,
          // otherwise we would wait for a response that never comes.
          pc_nxt    = target;
          state_nxt = imem_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (imem_rsp_valid) begin
          state_nxt = ST_REQ;
        end
      end

      ST_HALT: state_nxt = ST_HALT;

      default: state_nxt = ST_IDLE;
    endcase

    // A misaligned target freezes the PC and parks the engine until reset.
    if (redir && target_misalign) begin
      pc_nxt       = pc;
      state_nxt    = ST_HALT;
      misalign_nxt = 1'b1;
      capture      = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 1-cycle-latency instruction memory model.
// Inputs change #1 after each rising edge; outputs are sampled at the same point.
// Every expected value is hand-computed from the fetch/redirect rules.
module tb_fetch_ctrl;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            redirect_valid;
  logic [1:0]      redirect_sel;
  logic            redirect_taken;
  logic [XLEN-1:0] redirect_base;
  logic [XLEN-1:0] redirect_off;
  logic [XLEN-1:0] redirect_reg;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc4;
  logic            misalign_err;

  int checks;
  int failures;

  fetch_ctrl #(.XLEN(XLEN), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .redirect_taken (redirect_taken),
    .redirect_base  (redirect_base),
    .redirect_off   (redirect_off),
    .redirect_reg   (redirect_reg),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the memory model answers an accepted request one cycle later.
  task automatic tick();
    logic            hs;
    logic [XLEN-1:0] a;
    logic            r;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    r  = rst;
    @(posedge clk);
    #1;
    if (r) begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      imem_rsp_valid = hs;
      imem_rsp_data  = hs ? mem_word(a) : 32'h0;
    end
  endtask

  task automatic redirect(input logic [1:0] sel, input logic taken,
                          input logic [XLEN-1:0] base, input logic [XLEN-1:0] off,
                          input logic [XLEN-1:0] rr);
    redirect_valid = 1'b1;
    redirect_sel   = sel;
    redirect_taken = taken;
    redirect_base  = base;
    redirect_off   = off;
    redirect_reg   = rr;
  endtask

  task automatic no_redirect();
    redirect_valid = 1'b0;
    redirect_sel   = 2'b00;
    redirect_taken = 1'b0;
    redirect_base  = '0;
    redirect_off   = '0;
    redirect_reg   = '0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    no_redirect();
    #1;
    tick();
    tick();

    // Reset state
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_pc4", inst_pc4, 0);

    // Sequential fetch 0,4,8
    rst = 1'b0;
    tick();
    chk("seq_req0_valid", imem_req_valid, 1);
    chk("seq_req0_addr", imem_req_addr, 64'h0);
    tick();
    chk("seq_wait_no_req", imem_req_valid, 0);
    tick();
    chk("seq_inst0_valid", inst_valid, 1);
    chk("seq_inst0_pc", inst_pc, 64'h0);
    chk("seq_inst0_pc4", inst_pc4, 64'h4);
    chk("seq_inst0_data", inst, mem_word(64'h0));
    tick();
    chk("seq_req4_addr", imem_req_addr, 64'h4);
    tick();
    tick();
    chk("seq_inst4_pc", inst_pc, 64'h4);
    tick();
    chk("seq_req8_valid", imem_req_valid, 1);
    chk("seq_req8_addr", imem_req_addr, 64'h8);

    // Taken branch during WAIT drops the pending response
    tick();
    redirect(2'b01, 1'b1, 64'h10, 64'h20, 64'h0);
    tick();
    no_redirect();
    chk("br_req_valid", imem_req_valid, 1);
    chk("br_req_addr", imem_req_addr, 64'h30);
    chk("br_drop_inst_valid", inst_valid, 0);
    tick();
    chk("br_wait_inst_valid", inst_valid, 0);
    tick();
    chk("br_inst_pc", inst_pc, 64'h30);
    chk("br_inst_data", inst, mem_word(64'h30));

    // Decode stall: five cycles with inst_ready low
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_inst_valid", inst_valid, 1);
      chk("stall_inst_pc", inst_pc, 64'h30);
      chk("stall_inst_data", inst, mem_word(64'h30));
      chk("stall_no_req", imem_req_valid, 0);
    end
    inst_ready = 1'b1;
    tick();
    chk("stall_release_addr", imem_req_addr, 64'h34);

    // sel=00 ignored; JALR while request not accepted retargets the request
    imem_req_ready = 1'b0;
    redirect(2'b00, 1'b1, 64'h999, 64'h4, 64'h800);
    tick();
    chk("sel0_ignored_addr", imem_req_addr, 64'h34);
    redirect(2'b10, 1'b0, 64'h0, 64'h0, 64'h101);
    tick();
    no_redirect();
    imem_req_ready = 1'b1;
    chk("jalr_req_valid", imem_req_valid, 1);
    chk("jalr_req_addr", imem_req_addr, 64'h100);
    chk("jalr_no_misalign", misalign_err, 0);
    tick();
    tick();
    chk("jalr_inst_pc", inst_pc, 64'h100);
    chk("jalr_inst_pc4", inst_pc4, 64'h104);
    tick();
    chk("jalr_next_addr", imem_req_addr, 64'h104);

    // Not-taken branch coincident with handshake -> DRAIN
    redirect(2'b01, 1'b0, 64'h40, 64'h80, 64'h0);
    tick();
    no_redirect();
    chk("drain_no_req", imem_req_valid, 0);
    chk("drain_no_inst", inst_valid, 0);
    tick();
    chk("drain_discard_inst", inst_valid, 0);
    chk("drain_req_valid", imem_req_valid, 1);
    chk("drain_req_addr", imem_req_addr, 64'h44);
    tick();
    tick();
    chk("drain_inst_pc", inst_pc, 64'h44);
    chk("drain_inst_data", inst, mem_word(64'h44));

    // JAL while holding drops the held instruction even with inst_ready high
    redirect(2'b11, 1'b0, 64'h200, 64'h10, 64'h0);
    tick();
    no_redirect();
    chk("hold_jal_inst_valid", inst_valid, 0);
    chk("hold_jal_addr", imem_req_addr, 64'h210);

    // Reset while holding
    tick();
    tick();
    inst_ready = 1'b0;
    tick();
    chk("prerst_inst_valid", inst_valid, 1);
    rst = 1'b1;
    tick();
    chk("midrst_inst_valid", inst_valid, 0);
    chk("midrst_req_valid", imem_req_valid, 0);
    chk("midrst_inst_pc", inst_pc, 64'h0);
    rst = 1'b0;
    inst_ready = 1'b1;
    tick();
    chk("postrst_req_valid", imem_req_valid, 1);
    chk("postrst_req_addr", imem_req_addr, 64'h0);

    // Misaligned JALR -> one-cycle error pulse and HALT
    tick();
    redirect(2'b10, 1'b0, 64'h0, 64'h0, 64'h103);
    tick();
    no_redirect();
    chk("mis_pulse", misalign_err, 1);
    chk("mis_halt_no_req", imem_req_valid, 0);
    chk("mis_pc_unchanged", imem_req_addr, 64'h0);
    tick();
    chk("mis_pulse_end", misalign_err, 0);
    redirect(2'b11, 1'b0, 64'h500, 64'h0, 64'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("halt_no_req", imem_req_valid, 0);
      chk("halt_no_inst", inst_valid, 0);
      chk("halt_no_err", misalign_err, 0);
    end
    chk("halt_redirect_ignored", imem_req_addr, 64'h0);
    no_redirect();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("halt_exit_req_valid", imem_req_valid, 1);
    chk("halt_exit_addr", imem_req_addr, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter XLEN, default 64, address/PC width.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  in  1  rising-edge clock, single domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 redirect_valid  in  1  redirect request from execute.
REQ-006 redirect_sel  in  2  01 branch, 10 JALR, 11 JAL; 00 = no redirect.
REQ-007 redirect_taken  in  1  branch outcome, used only when sel=01.
REQ-008 redirect_base  in  XLEN  PC of redirecting instruction.
REQ-009 redirect_off  in  XLEN  immediate offset (branch/JAL).
REQ-010 redirect_reg  in  XLEN  rs1+imm (JALR).
REQ-011 imem_req_valid  out  1; imem_req_ready  in  1; imem_req_addr  out  XLEN: fetch request.
REQ-012 imem_rsp_valid  in  1; imem_rsp_data  in  32: fetch response, one per accepted request, in order.
REQ-013 inst_valid  out  1; inst_ready  in  1; inst  out  32; inst_pc  out  XLEN; inst_pc4  out  XLEN: decode handoff.
REQ-014 misalign_err  out  1  one-cycle pulse on misaligned redirect target.

Function
REQ-015 FSM states IDLE, REQ, WAIT, HOLD, DRAIN, HALT; at most one outstanding imem request.
REQ-016 Outputs: imem_req_valid=1 only in REQ; inst_valid=1 only in HOLD; imem_req_addr=pc register.
REQ-017 IDLE -> REQ unconditionally next cycle.
REQ-018 REQ: imem_req_valid&&imem_req_ready -> WAIT, latching request address as fetch_pc.
REQ-019 WAIT: imem_rsp_valid -> HOLD, registering inst=imem_rsp_data, inst_pc=fetch_pc, inst_pc4=fetch_pc+4; latency request-accept to inst_valid is rsp latency +1 cycle.
REQ-020 HOLD: inst, inst_pc, inst_pc4 stable while inst_valid && !inst_ready; inst_ready -> REQ with pc=inst_pc+4.
REQ-021 Target: branch taken base+off; branch not taken base+4; JAL base+off; JALR reg & ~1; all arithmetic modulo 2^XLEN.
REQ-022 Target[1:0]!=0: pc unchanged, misalign_err pulses one cycle, state -> HALT; HALT exits only on rst.
REQ-023 Valid redirect in REQ without handshake: pc=target, stay REQ (address may change while unaccepted).
REQ-024 Redirect in REQ coinciding with handshake: pc=target, -> DRAIN.
REQ-025 Redirect in WAIT: pc=target, -> DRAIN; same-cycle imem_rsp_valid is discarded and state -> REQ instead.
REQ-026 DRAIN: next imem_rsp_valid discarded (never reaches inst), -> REQ; further redirects in DRAIN update pc, stay DRAIN.
REQ-027 Redirect in HOLD: held instruction dropped (inst_valid low next cycle even if inst_ready same cycle), pc=target, -> REQ.
REQ-028 Redirect with redirect_sel=00 or in IDLE/HALT: ignored.

Reset
REQ-029 On rst: state=IDLE, pc=RESET_PC, fetch_pc=0, inst/inst_pc/inst_pc4=0, misalign_err=0; all valids 0 the cycle after rst sampled.
REQ-030 Reset mid-operation abandons any outstanding request; imem is reset by the same rst and returns no stale response.

Structure
REQ-031 Package fetch_pkg holds state enum, redirect_sel encodings (SEL_NONE/BRANCH/JALR/JAL), XLEN default.
REQ-032 Sub-module fetch_target: combinational target and misalign computation from redirect inputs.

Verification
REQ-033 Reset, imem ready always, 1-cycle rsp, inst_ready=1 -> req addrs 0,4,8; first inst_pc=0, inst_pc4=4.
REQ-034 Branch taken base=0x10 off=0x20 during WAIT -> pending rsp dropped, next req addr 0x30, no inst_valid for dropped rsp.
REQ-035 JALR reg=0x101 -> next addr 0x100; JALR reg=0x103 -> misalign_err one cycle, HALT, no further requests until rst.
REQ-036 inst_ready low 5 cycles in HOLD -> inst_valid held, inst/inst_pc stable, imem_req_valid 0 throughout.
REQ-037 Branch not-taken base=0x40 coincident with req handshake -> DRAIN, next rsp discarded, next req addr 0x44.
REQ-038 rst asserted in HOLD -> inst_valid 0 next cycle, IDLE, then req addr RESET_PC.
